// File: rtl/snes_frame_decoder.sv
// Passive SNES controller frame decoder. It deserialises the 16-bit frame and derives the facing direction.
// Latency is SYNC_STAGES+2 clk_system cycles from the 15th clk_ctrl fall to frame_valid. There is no backpressure, because it is a pure monitor.
module snes_frame_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk_system,
    input  logic        reset,
    input  logic        ctrl_latch,
    input  logic        clk_ctrl,
    input  logic        ctrl_data,
    output logic [15:0] buttons,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        dir,
    output logic        busy
);

    localparam int TW = ($clog2(TIMEOUT) + 1 > 11) ? $clog2(TIMEOUT) + 1 : 11;

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] cclk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   latch_hist;
    logic                   cclk_hist;
    logic [15:0]            shreg;
    logic [3:0]             bitcnt;
    logic [TW-1:0]          timer;

    logic latch_s;
    logic cclk_s;
    logic data_s;
    logic latch_rise;
    logic latch_fall;
    logic cclk_fall;

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign cclk_s     = cclk_sync[SYNC_STAGES-1];
    assign data_s     = data_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_hist;
    assign latch_fall = ~latch_s & latch_hist;
    assign cclk_fall  = ~cclk_s & cclk_hist;

    always_ff @(posedge clk_system) begin
        if (reset) begin
            latch_sync <= '0;
            cclk_sync  <= '0;
            data_sync  <= '0;
            latch_hist <= 1'b0;
            cclk_hist  <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], ctrl_latch};
            cclk_sync  <= {cclk_sync[SYNC_STAGES-2:0], clk_ctrl};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ctrl_data};
            latch_hist <= latch_s;
            cclk_hist  <= cclk_s;
        end
    end

    always_ff @(posedge clk_system) begin
        if (reset) begin
            state       <= IDLE;
            buttons     <= 16'h0000;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            dir         <= 1'b0;
            busy        <= 1'b0;
            bitcnt      <= 4'd0;
            timer       <= '0;
            shreg       <= 16'h0000;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (latch_rise) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (latch_fall) begin
                        shreg  <= {shreg[14:0], ~data_s};
                        bitcnt <= 4'd1;
                        timer  <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A new latch restarts the frame even if a clock fall lands in the same cycle.
                    if (latch_rise) begin
                        frame_error <= 1'b1;
                        bitcnt      <= 4'd0;
                        timer       <= '0;
                        state       <= LATCH;
                    end else if (cclk_fall) begin
                        shreg  <= {shreg[14:0], ~data_s};
                        timer  <= '0;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd15) begin
                            state <= DONE;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        frame_error <= 1'b1;
                        bitcnt      <= 4'd0;
                        timer       <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    bitcnt <= 4'd0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                    // Trailing bits are never pressed on a real pad, so a pressed tail marks a corrupt frame.
                    if (shreg[3:0] == 4'h0) begin
                        buttons     <= shreg;
                        frame_valid <= 1'b1;
                        if (shreg[9] && !shreg[8]) begin
                            dir <= 1'b1;
                        end else if (shreg[8] && !shreg[9]) begin
                            dir <= 1'b0;
                        end
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_frame_decoder.sv
// Directed bench for snes_frame_decoder: table-driven frames plus abort, timeout and reset sequences.
module tb_snes_frame_decoder;

    localparam int SS = 2;
    localparam int TO = 64;
    localparam int HP = 6;

    logic        clk_system = 1'b0;
    logic        reset      = 1'b1;
    logic        ctrl_latch = 1'b0;
    logic        clk_ctrl   = 1'b0;
    logic        ctrl_data  = 1'b1;
    logic [15:0] buttons;
    logic        frame_valid;
    logic        frame_error;
    logic        dir;
    logic        busy;

    snes_frame_decoder #(.SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk_system (clk_system),
        .reset      (reset),
        .ctrl_latch (ctrl_latch),
        .clk_ctrl   (clk_ctrl),
        .ctrl_data  (ctrl_data),
        .buttons    (buttons),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .dir        (dir),
        .busy       (busy)
    );

    always #5 clk_system = ~clk_system;

    int cyc = 0;
    always @(posedge clk_system) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = -1;
    int fall15_cyc = 0;
    logic [15:0] prev_buttons = 16'h0000;
    logic prev_reset = 1'b1;
    logic prev_fv = 1'b0;
    logic prev_fe = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counting and invariants that must hold at every cycle.
    always @(negedge clk_system) begin
        if (!reset && !prev_reset) begin
            if (frame_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (frame_error) n_err++;
            if (frame_valid || frame_error) begin
                check("valid_error_exclusive", int'(frame_valid && frame_error), 0);
                check("pulse_width", int'((frame_valid && prev_fv) || (frame_error && prev_fe)), 0);
            end
            if (buttons != prev_buttons)
                check("buttons_change_with_valid", int'(frame_valid), 1);
        end
        prev_buttons = buttons;
        prev_reset   = reset;
        prev_fv      = frame_valid;
        prev_fe      = frame_error;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_system);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] s, input int nclk);
        ctrl_data  = s[15];
        ctrl_latch = 1'b1;
        cycles(HP);
        ctrl_latch = 1'b0;
        cycles(HP);
        for (int i = 1; i <= nclk; i++) begin
            clk_ctrl  = 1'b1;
            ctrl_data = (i <= 15) ? s[15-i] : 1'b1;
            cycles(HP);
            clk_ctrl = 1'b0;
            if (i == 15) fall15_cyc = cyc;
            cycles(HP);
        end
        ctrl_data = 1'b1;
    endtask

    typedef struct {
        logic [15:0] serial;
        logic [15:0] exp_buttons;
        logic        exp_dir;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0;
        int e0;

        vecs[0] = '{16'hBFFF, 16'h4000, 1'b0, 1, 0};
        vecs[1] = '{16'hFDFF, 16'h0200, 1'b1, 1, 0};
        vecs[2] = '{16'hFEFF, 16'h0100, 1'b0, 1, 0};
        vecs[3] = '{16'hFCFF, 16'h0300, 1'b0, 1, 0};
        vecs[4] = '{16'hFFF0, 16'h0300, 1'b0, 0, 1};
        vecs[5] = '{16'hFDFF, 16'h0200, 1'b1, 1, 0};
        vecs[6] = '{16'hFEF0, 16'h0200, 1'b1, 0, 1};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 1, 0};

        reset = 1'b1;
        cycles(3);
        check("reset_buttons", int'(buttons), 0);
        check("reset_valid", int'(frame_valid), 0);
        check("reset_error", int'(frame_error), 0);
        check("reset_dir", int'(dir), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        cycles(2);

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid;
            e0 = n_err;
            last_valid_cyc = -1;
            send_frame(vecs[i].serial, 16);
            cycles(10);
            check($sformatf("vec%0d_buttons", i), int'(buttons), int'(vecs[i].exp_buttons));
            check($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].exp_dir));
            check($sformatf("vec%0d_valid_count", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_error_count", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
            if (vecs[i].exp_valid == 1)
                check($sformatf("vec%0d_latency", i), last_valid_cyc - fall15_cyc, SS + 2);
        end

        // Mid-frame abort after 7 samples, then a clean frame.
        v0 = n_valid;
        e0 = n_err;
        send_frame(16'h0000, 6);
        check("abort_busy_mid", int'(busy), 1);
        send_frame(16'hBFFF, 16);
        cycles(10);
        check("abort_error_count", n_err - e0, 1);
        check("abort_valid_count", n_valid - v0, 1);
        check("abort_buttons", int'(buttons), 16'h4000);
        check("abort_dir", int'(dir), 1);

        // Clock stalls after 3 pulses.
        v0 = n_valid;
        e0 = n_err;
        send_frame(16'hFDFF, 3);
        cycles(5);
        check("timeout_busy_before", int'(busy), 1);
        cycles(TO + 10);
        check("timeout_error_count", n_err - e0, 1);
        check("timeout_valid_count", n_valid - v0, 0);
        check("timeout_busy_after", int'(busy), 0);
        check("timeout_buttons", int'(buttons), 16'h4000);

        // Reset after 9 samples.
        send_frame(16'h0000, 8);
        e0 = n_err;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("midreset_buttons", int'(buttons), 0);
        check("midreset_dir", int'(dir), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(frame_valid), 0);
        check("midreset_error", int'(frame_error), 0);
        cycles(20);
        check("midreset_no_error", n_err - e0, 0);
        v0 = n_valid;
        send_frame(16'hFDFF, 16);
        cycles(10);
        check("postreset_valid_count", n_valid - v0, 1);
        check("postreset_buttons", int'(buttons), 16'h0200);
        check("postreset_dir", int'(dir), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
